// File: rtl/debug_sequencer.sv
// Debugger control FSM: runs or steps the MIPS pipeline on UART commands and
// streams a PC / register file / data-memory dump back over the UART.
module debug_sequencer #(
  parameter int unsigned MEM_WORDS  = 32,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        inicio,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        finalW,
  input  logic [8:0]  pcf,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_data,
  output logic        activo,
  output logic        pipe_inicio,
  output logic        mem_in,
  output logic [11:0] add_in,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_RST, S_IDLE, S_STEP, S_RUN, S_PC,
    S_REG_LD, S_REG_TX, S_MEM_ADDR, S_MEM_WAIT, S_MEM_TX
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [11:0] MEM_LAST = 12'(MEM_WORDS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_rst_cnt;
  logic        r_halted;
  logic [31:0] r_shift;
  logic [1:0]  r_byte;
  logic [4:0]  r_reg;
  logic [11:0] r_addr;

  logic w_tx_valid;
  logic w_activo;
  logic w_mem_in;
  logic w_pipe_inicio;
  logic w_fire;
  logic w_word_done;
  logic w_enter_pc;

  assign w_fire      = w_tx_valid & tx_ready;
  assign w_word_done = w_fire & (r_byte == 2'd3);
  assign w_enter_pc  = (w_next == S_PC) && (r_state != S_PC);

  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) r_state <= S_RST;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_tx_valid    = 1'b0;
    w_activo      = 1'b0;
    w_mem_in      = 1'b0;
    w_pipe_inicio = 1'b0;
    case (r_state)
      S_RST: begin
        w_pipe_inicio = 1'b1;
        if (r_rst_cnt == RST_LAST) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h73:   w_next = r_halted ? S_PC : S_STEP;
            8'h63:   w_next = r_halted ? S_PC : S_RUN;
            8'h72:   w_next = S_RST;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_STEP: begin
        w_activo = 1'b1;
        w_next   = S_PC;
      end
      S_RUN: begin
        w_activo = 1'b1;
        if (finalW) w_next = S_PC;
      end
      S_PC: begin
        w_tx_valid = 1'b1;
        if (w_word_done) w_next = S_REG_LD;
      end
      S_REG_LD: w_next = S_REG_TX;
      S_REG_TX: begin
        w_tx_valid = 1'b1;
        if (w_word_done) w_next = (r_reg == 5'd31) ? S_MEM_ADDR : S_REG_LD;
      end
      S_MEM_ADDR: begin
        w_mem_in = 1'b1;
        w_next   = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        w_mem_in = 1'b1;
        w_next   = S_MEM_TX;
      end
      S_MEM_TX: begin
        w_mem_in   = 1'b1;
        w_tx_valid = 1'b1;
        if (w_word_done) w_next = (r_addr == MEM_LAST) ? S_IDLE : S_MEM_ADDR;
      end
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge inicio) begin
    if (!inicio) begin
      r_rst_cnt <= '0;
      r_halted  <= 1'b0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_reg     <= '0;
      r_addr    <= '0;
    end else begin
      if (r_state == S_RST) begin
        r_rst_cnt <= r_rst_cnt + 16'd1;
        r_halted  <= 1'b0;
      end else begin
        r_rst_cnt <= '0;
      end
      if (w_activo && finalW) r_halted <= 1'b1;
      // PC is two bytes: preload the index at 2 so the shared 3->0 wrap ends it.
      if (w_enter_pc) begin
        r_shift <= {7'b0, pcf, 16'h0000};
        r_byte  <= 2'd2;
      end
      case (r_state)
        S_REG_LD: begin
          r_shift <= reg_data;
          r_byte  <= '0;
        end
        S_MEM_WAIT: begin
          r_shift <= mem_data;
          r_byte  <= '0;
        end
        default: begin
          if (w_fire) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_byte  <= r_byte + 2'd1;
          end
        end
      endcase
      if (r_state == S_REG_TX && w_word_done)
        r_reg <= (r_reg == 5'd31) ? 5'd0 : r_reg + 5'd1;
      if (r_state == S_MEM_TX && w_word_done)
        r_addr <= (r_addr == MEM_LAST) ? 12'd0 : r_addr + 12'd1;
    end
  end

  assign tx_valid    = w_tx_valid;
  assign tx_data     = w_tx_valid ? r_shift[31:24] : '0;
  assign activo      = w_activo;
  assign pipe_inicio = w_pipe_inicio;
  assign mem_in      = w_mem_in;
  assign add_in      = r_addr;
  assign reg_sel     = r_reg;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer with a register-file / data-memory model.
module tb_debug_sequencer;

  logic        clk;
  logic        inicio;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        finalW;
  logic [8:0]  pcf;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic        activo;
  logic        pipe_inicio;
  logic        mem_in;
  logic [11:0] add_in;
  logic        busy;

  logic [31:0] regs [32];
  logic [31:0] mem  [4096];
  logic [7:0]  cap  [$];

  int nvec = 0;
  int nerr = 0;
  int act_cnt, pipe_cnt, busy_cnt, memin_bad, add_bad, add_last, stab_bad;
  logic prev_hold;
  logic [7:0] prev_data;
  logic rand_ready;

  debug_sequencer #(.MEM_WORDS(32), .RST_CYCLES(2)) dut (
    .clk(clk), .inicio(inicio), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .finalW(finalW), .pcf(pcf), .reg_sel(reg_sel), .reg_data(reg_data),
    .mem_data(mem_data), .activo(activo), .pipe_inicio(pipe_inicio),
    .mem_in(mem_in), .add_in(add_in), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign reg_data = regs[reg_sel];
  always @(posedge clk) mem_data <= mem[add_in];

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Observer: sampled 1 time unit after the falling edge, i.e. the values the next rising edge will see.
  initial begin
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (activo) act_cnt++;
      if (pipe_inicio) pipe_cnt++;
      if (busy) busy_cnt++;
      if (mem_in && cap.size() < 130) memin_bad++;
      if (!mem_in && busy && inicio && cap.size() >= 130 && cap.size() < 258) memin_bad++;
      if (mem_in) begin
        if (int'(add_in) != add_last) begin
          if (int'(add_in) != add_last + 1) add_bad++;
          add_last = int'(add_in);
        end
      end else if (add_in != 12'd0) begin
        add_bad++;
      end
      if (inicio && prev_hold && (!tx_valid || tx_data != prev_data)) stab_bad++;
      prev_hold = inicio && tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid && tx_ready) cap.push_back(tx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (busy && n < budget);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic clear_obs();
    cap.delete();
    act_cnt   = 0;
    memin_bad = 0;
    add_bad   = 0;
    add_last  = 0;
    stab_bad  = 0;
  endtask

  task automatic chk_pc(input string tag, input logic [8:0] pc);
    chk({tag, "_len"}, cap.size(), 32'd258);
    if (cap.size() == 258) begin
      chk({tag, "_pc_hi"}, {24'b0, cap[0]}, {31'b0, pc[8]});
      chk({tag, "_pc_lo"}, {24'b0, cap[1]}, {24'b0, pc[7:0]});
    end
  endtask

  task automatic chk_dump_body(input string tag);
    logic [31:0] exp_r5;
    logic [31:0] exp_m0;
    exp_r5 = 32'hDEADBEEF;
    exp_m0 = 32'h11223344;
    if (cap.size() == 258) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_r5_b%0d", tag, i), {24'b0, cap[22 + i]}, {24'b0, exp_r5[31 - 8*i -: 8]});
        chk($sformatf("%s_m0_b%0d", tag, i), {24'b0, cap[130 + i]}, {24'b0, exp_m0[31 - 8*i -: 8]});
        chk($sformatf("%s_m31_b%0d", tag, i), {24'b0, cap[254 + i]}, 32'h000000A5);
      end
      chk({tag, "_r0_b0"}, {24'b0, cap[2]}, 32'd0);
    end
    chk({tag, "_memin_phase"}, memin_bad, 32'd0);
    chk({tag, "_add_seq"}, add_bad, 32'd0);
    chk({tag, "_add_last"}, add_last, 32'd31);
  endtask

  initial begin
    inicio     = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b1;
    finalW     = 1'b0;
    pcf        = 9'h104;
    rand_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    regs[5]  = 32'hDEADBEEF;
    mem[0]   = 32'h11223344;
    mem[31]  = 32'hA5A5A5A5;
    clear_obs();

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    chk("rst_pipe_inicio", {31'b0, pipe_inicio}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_activo", {31'b0, activo}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_mem_in", {31'b0, mem_in}, 32'd0);
    chk("rst_add_in", {20'b0, add_in}, 32'd0);
    chk("rst_reg_sel", {27'b0, reg_sel}, 32'd0);
    @(posedge clk);
    #1;
    inicio   = 1'b1;
    pipe_cnt = 0;
    repeat (6) @(negedge clk);
    #2;
    chk("rel_pipe_cycles", pipe_cnt, 32'd2);
    chk("rel_busy", {31'b0, busy}, 32'd0);
    chk("rel_activo", {31'b0, activo}, 32'd0);
    chk("rel_tx_valid", {31'b0, tx_valid}, 32'd0);

    // Single step, full dump at full rate
    clear_obs();
    send_cmd(8'h73);
    wait_idle(3000, "step");
    chk("step_activo_cycles", act_cnt, 32'd1);
    chk_pc("step", 9'h104);
    chk_dump_body("step");

    // Run to halt after 40 active cycles
    clear_obs();
    pcf = 9'h1AB;
    send_cmd(8'h63);
    repeat (39) @(negedge clk);
    finalW = 1'b1;
    @(negedge clk);
    finalW = 1'b0;
    wait_idle(3000, "run");
    chk("run_activo_cycles", act_cnt, 32'd40);
    chk_pc("run", 9'h1AB);
    chk_dump_body("run");

    // Halted: continue dumps without running
    clear_obs();
    send_cmd(8'h63);
    wait_idle(3000, "halted");
    chk("halted_activo_cycles", act_cnt, 32'd0);
    chk_pc("halted", 9'h1AB);

    // Random backpressure with a command injected mid-dump
    clear_obs();
    rand_ready = 1'b1;
    send_cmd(8'h63);
    repeat (50) @(negedge clk);
    send_cmd(8'h73);
    wait_idle(6000, "bp");
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    busy_cnt   = 0;
    repeat (20) @(negedge clk);
    #2;
    chk("bp_injected_dropped", busy_cnt, 32'd0);
    chk("bp_stable", stab_bad, 32'd0);
    chk("bp_activo_cycles", act_cnt, 32'd0);
    chk_pc("bp", 9'h1AB);
    chk_dump_body("bp");

    // Reset command clears halted
    pipe_cnt = 0;
    send_cmd(8'h72);
    repeat (6) @(negedge clk);
    #2;
    chk("rcmd_pipe_cycles", pipe_cnt, 32'd2);
    chk("rcmd_busy", {31'b0, busy}, 32'd0);
    clear_obs();
    pcf = 9'h0C3;
    send_cmd(8'h73);
    wait_idle(3000, "rcmd_step");
    chk("rcmd_step_activo", act_cnt, 32'd1);
    chk_pc("rcmd_step", 9'h0C3);

    // Asynchronous reset at dump byte 100
    clear_obs();
    pcf = 9'h155;
    send_cmd(8'h73);
    begin
      int n;
      n = 0;
      while (cap.size() < 100 && n < 2000) begin
        @(negedge clk);
        #2;
        n++;
      end
    end
    chk("abort_reached", {31'b0, cap.size() >= 100}, 32'd1);
    inicio = 1'b0;
    #1;
    chk("abort_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("abort_pipe_inicio", {31'b0, pipe_inicio}, 32'd1);
    chk("abort_mem_in", {31'b0, mem_in}, 32'd0);
    @(posedge clk);
    #1;
    inicio = 1'b1;
    wait_idle(20, "abort_rst");
    clear_obs();
    send_cmd(8'h73);
    wait_idle(3000, "abort_restart");
    chk("abort_restart_activo", act_cnt, 32'd1);
    chk_pc("abort_restart", 9'h155);
    chk_dump_body("abort_restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Command-driven controller that sequences the 5-stage MIPS pipeline for the debugger.
- Receives command bytes from the UART receiver and drives the pipeline's `activo`, `inicio`, `mem_in` and `add_in` controls.
- After each run or step, streams a state dump byte-by-byte to the UART transmitter: PC, then the 32 registers, then a data-memory window.
- Sits between the UART rx/tx blocks and the pipeline top.

Parameters:
- MEM_WORDS, 32: number of data-memory words dumped, starting at address 0 (range 1..4096).
- RST_CYCLES, 2: cycles `pipe_inicio` is held high for a reset command or after controller reset.

Ports:
- clk  in  1  system clock.
- inicio  in  1  asynchronous active-low reset.
- rx_data  in  8  received command byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte.
- finalW  in  1  halt instruction reached write-back.
- pcf  in  9  pipeline fetch PC.
- reg_sel  out  5  register index for the external register mux.
- reg_data  in  32  selected register value (combinational from reg_sel).
- mem_data  in  32  data-memory read port (ReadDataM); synchronous, 1-cycle latency.
- activo  out  1  pipeline clock-enable.
- pipe_inicio  out  1  active-high pipeline reset.
- mem_in  out  1  selects add_in as the data-memory address.
- add_in  out  12  debug memory address.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (inicio=0, asynchronous) puts the outputs in these states:
  - state=RST, activo=0, pipe_inicio=1, mem_in=0, add_in=0, reg_sel=0, tx_valid=0, tx_data=0, busy=1, halted=0.
  - Reset mid-dump or mid-run aborts immediately; no partial byte is retried.
- RST: pipe_inicio=1 for RST_CYCLES clocks after reset release, then IDLE with pipe_inicio=0 and halted cleared.
- IDLE: samples rx_data when rx_valid=1.
  - 0x73 's': if halted, go to DUMP; else STEP.
  - 0x63 'c': if halted, go to DUMP; else RUN.
  - 0x72 'r': go to RST.
  - Any other byte: ignored.
- rx_valid outside IDLE is dropped with no queueing.
- STEP: activo=1 for exactly one clock, then DUMP. If finalW=1 is sampled in that cycle, set halted.
- RUN: activo=1 every clock until finalW=1 is sampled. activo is 0 from the next cycle, halted=1, then DUMP. RUN has no timeout; only reset leaves it otherwise.
- activo is 0 in every state other than STEP and RUN.
- DUMP sequence (byte order fixed, each word MSB first):
  1. PC: pcf is latched on DUMP entry. Send 2 bytes: {7'b0,pc[8]}, pc[7:0].
  2. Registers: for r=0..31, set reg_sel=r for one cycle (REG_LD), capture reg_data into the shift register, send 4 bytes.
  3. Memory: set mem_in=1 for the whole memory phase. For a=0..MEM_WORDS-1:
     - MEM_ADDR: drive add_in=a.
     - MEM_WAIT: one cycle.
     - Capture mem_data, send 4 bytes.
     - add_in increments after the 4th byte of each word.
  4. After the last byte: mem_in=0, add_in=0, reg_sel=0, return to IDLE.
- Total dump length is 130+4*MEM_WORDS bytes (258 at default).
- Tx handshake:
  - tx_valid rises with tx_data.
  - Both are held stable until a rising edge where tx_valid=1 and tx_ready=1; the byte is consumed on that edge.
  - The next byte may be presented on the following cycle.
  - tx_ready=1 while tx_valid=0 has no effect.
  - Unlimited backpressure is allowed.
- Counters: byte index is 2 bits and wraps 3→0 per word. Register index is 5 bits and terminates at 31 with no wrap. Memory index is 12 bits and terminates at MEM_WORDS-1.
- Simultaneous events:
  - finalW and rx_valid in RUN: finalW handled, rx dropped.
  - Async reset overrides everything.

Test Plan:
- Reset: hold inicio=0, release → pipe_inicio=1 for exactly 2 cycles, then busy=0, activo=0, tx_valid=0.
- Step: send 0x73 with pcf=9'h104 and reg r5=32'hDEADBEEF, rest 0, tx_ready=1 → activo high exactly 1 cycle. Then 258 bytes: 0x01,0x04, ..., register-5 bytes DE,AD,BE,EF at stream offsets 22..25.
- Run-to-halt: send 0x63, assert finalW after 40 cycles → activo high 40 cycles then low, dump follows. A further 0x63 gives a dump with activo never asserted.
- Memory dump: preload mem[0]=0x11223344, mem[31]=0xA5A5A5A5 → mem_in=1 only during the memory phase, add_in steps 0..31. Bytes 130..133=11,22,33,44; bytes 254..257=A5 ×4.
- Backpressure/drop: toggle tx_ready randomly, and inject 0x73 mid-dump → tx_data never changes while tx_valid=1 without tx_ready, byte count stays 258, injected command ignored.
- Reset command and async abort:
  - 0x72 in IDLE → pipe_inicio pulses 2 cycles and halted clears.
  - inicio=0 at dump byte 100 → tx_valid=0 immediately; the post-reset 0x73 dump restarts at the PC bytes.
